// File: rtl/sc_div_pkg.sv
// sc_div_pkg: shared constants for the stochastic divide path.
// LFSR tap masks, default seed and input-pair bit positions.
package sc_div_pkg;

  localparam int DIVISOR_BIT  = 1;
  localparam int DIVIDEND_BIT = 0;

  localparam logic [7:0] DEFAULT_SEED = 8'hA5;

  // Fibonacci feedback masks (bit n-1 = x^n term), widths 2..16.
  // Unsupported widths return 0, which freezes the register.
  function automatic logic [31:0] taps_for(input int width);
    logic [31:0] m;
    case (width)
      2:       m = 32'h0003;
      3:       m = 32'h0006;
      4:       m = 32'h000C;
      5:       m = 32'h0014;
      6:       m = 32'h0030;
      7:       m = 32'h0060;
      8:       m = 32'h00B8;
      9:       m = 32'h0110;
      10:      m = 32'h0240;
      11:      m = 32'h0500;
      12:      m = 32'h0E08;
      13:      m = 32'h1C80;
      14:      m = 32'h3802;
      15:      m = 32'h6000;
      16:      m = 32'hD008;
      default: m = 32'h0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sc_lfsr.sv
// sc_lfsr: maximal-length Fibonacci LFSR, one step per enable.
// Shared by the trace-back logic and upstream number generators.
module sc_lfsr
  import sc_div_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] state
);

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(taps_for(WIDTH));

  logic fb;

  assign fb = ^(state & TAPS);

  // Shift left, feedback into bit 0; hold when not enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEED;
    end else if (en) begin
      state <= {state[WIDTH-2:0], fb};
    end
  end

endmodule

// File: rtl/sc_cordiv.sv
// sc_cordiv: correlated stochastic divider with history trace-back.
// Also counts quotient ones over a 2^CNT_W window for readout.
module sc_cordiv
  import sc_div_pkg::*;
#(
  parameter int                DEPTH  = 4,
  parameter int                LFSR_W = 8,
  parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(DEFAULT_SEED),
  parameter int                CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       in,
  output logic             quo,
  output logic [CNT_W-1:0] result,
  output logic             done,
  output logic             err
);

  localparam int SEL_W = $clog2(DEPTH);
  localparam logic [CNT_W:0] MAX = {1'b0, {CNT_W{1'b1}}};

  logic [LFSR_W-1:0] lfsr_q;
  logic [SEL_W-1:0]  sel;
  logic              lfsr_unused;
  logic [DEPTH-1:0]  hist;
  logic              div;
  logic              dvd;
  logic              q;
  logic              illegal;
  logic [CNT_W-1:0]  cyc;
  logic [CNT_W:0]    ones;
  logic [CNT_W:0]    ones_nx;
  logic [CNT_W-1:0]  sat;

  sc_lfsr #(
    .WIDTH (LFSR_W),
    .SEED  (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .state (lfsr_q)
  );

  assign sel         = lfsr_q[SEL_W-1:0];
  assign lfsr_unused = ^lfsr_q[LFSR_W-1:SEL_W];

  // Quotient select: pass dividend when divisor set, else trace back.
  always_comb begin
    div     = in[DIVISOR_BIT];
    dvd     = in[DIVIDEND_BIT];
    illegal = !div && dvd;
    q       = div ? dvd : hist[sel];
    ones_nx = ones + {{CNT_W{1'b0}}, q};
    sat     = (ones_nx > MAX) ? MAX[CNT_W-1:0]
                              : ones_nx[CNT_W-1:0];
  end

  // History only records dividend bits seen under a divisor one.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist <= '0;
    end else if (en && div) begin
      hist <= {hist[DEPTH-2:0], dvd};
    end
  end

  // Registered quotient and sticky illegal-pair flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      quo <= 1'b0;
      err <= 1'b0;
    end else if (en) begin
      quo <= q;
      if (illegal) begin
        err <= 1'b1;
      end
    end
  end

  // Window accumulator; publishes saturated count on last cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc    <= '0;
      ones   <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (en) begin
        cyc <= cyc + 1'b1;
        if (&cyc) begin
          result <= sat;
          done   <= 1'b1;
          ones   <= '0;
        end else begin
          ones <= ones_nx;
        end
      end
    end
  end

endmodule
